// File: rtl/cnt_hms_pkg.sv
// cnt_hms_pkg - shared FSM state type and time constants for the seconds-to-HMS converter.
// Rev 1.0
`default_nettype none

package cnt_hms_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOURS = 2'd1,
    MINS  = 2'd2,
    DONE  = 2'd3
  } hms_state_t;

  localparam int SEC_PER_MIN = 60;
  localparam int SEC_PER_HR  = 3600;
  localparam int DAY_SECS    = 86400;

endpackage

`default_nettype wire

// File: rtl/cnt_bin2bcd.sv
// cnt_bin2bcd - combinational 0..59 binary to two-digit BCD.
// Rev 1.0
`default_nettype none

module cnt_bin2bcd (
  input  logic [5:0] i_bin,
  output logic [7:0] o_bcd
);

  logic [2:0] w_tens;
  logic [3:0] w_tens_x10;
  logic [3:0] w_ones;

  always_comb begin
    w_tens = 3'd0;
    if      (i_bin >= 6'd50) w_tens = 3'd5;
    else if (i_bin >= 6'd40) w_tens = 3'd4;
    else if (i_bin >= 6'd30) w_tens = 3'd3;
    else if (i_bin >= 6'd20) w_tens = 3'd2;
    else if (i_bin >= 6'd10) w_tens = 3'd1;
  end

  // The ones digit is always < 10, so arithmetic modulo 16 on the low nibble is exact.
  assign w_tens_x10 = {w_tens[0], 3'b000} + {w_tens, 1'b0};
  assign w_ones     = i_bin[3:0] - w_tens_x10;
  assign o_bcd      = {1'b0, w_tens, w_ones};

endmodule

`default_nettype wire

// File: rtl/cnt_sec_to_hms.sv
// cnt_sec_to_hms - seconds-of-day to hours/minutes/seconds by repeated subtraction, valid/ready both sides.
// Rev 1.0. Optional BCD readout port out_bcd enabled by defining CNT_HMS_BCD_EN.
`default_nettype none

module cnt_sec_to_hms
  import cnt_hms_pkg::*;
#(
  parameter int CNT_W     = 17,
  parameter int MAX_COUNT = DAY_SECS
) (
  input  logic             cnt_clk,
  input  logic             cnt_rst,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_count,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_hours,
  output logic [5:0]       out_mins,
  output logic [5:0]       out_secs,
  output logic             out_err
`ifdef CNT_HMS_BCD_EN
  ,
  output logic [23:0]      out_bcd
`endif
);

  localparam logic [CNT_W-1:0] c_max     = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] c_sec_hr  = CNT_W'(SEC_PER_HR);
  localparam logic [CNT_W-1:0] c_sec_min = CNT_W'(SEC_PER_MIN);

  hms_state_t       r_state;
  logic [CNT_W-1:0] r_rem;
  logic [4:0]       r_hrs;
  logic [5:0]       r_mins;

  assign in_ready = (r_state == IDLE) && !cnt_rst;

`ifdef CNT_HMS_BCD_EN
  logic [7:0]  w_bcd_hh;
  logic [7:0]  w_bcd_mm;
  logic [7:0]  w_bcd_ss;
  logic [23:0] w_bcd;

  cnt_bin2bcd u_bcd_hh (.i_bin({1'b0, r_hrs}), .o_bcd(w_bcd_hh));
  cnt_bin2bcd u_bcd_mm (.i_bin(r_mins),        .o_bcd(w_bcd_mm));
  cnt_bin2bcd u_bcd_ss (.i_bin(r_rem[5:0]),    .o_bcd(w_bcd_ss));

  assign w_bcd = {w_bcd_hh, w_bcd_mm, w_bcd_ss};
`endif

  always_ff @(posedge cnt_clk or posedge cnt_rst) begin
    if (cnt_rst) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_hrs     <= '0;
      r_mins    <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_hours <= '0;
      out_mins  <= '0;
      out_secs  <= '0;
`ifdef CNT_HMS_BCD_EN
      out_bcd   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_rem  <= in_count;
            r_hrs  <= '0;
            r_mins <= '0;
            if (in_count > c_max) begin
              r_state   <= DONE;
              out_err   <= 1'b1;
              out_hours <= '0;
              out_mins  <= '0;
              out_secs  <= '0;
`ifdef CNT_HMS_BCD_EN
              out_bcd   <= '0;
`endif
            end else begin
              r_state <= HOURS;
            end
          end
        end
        HOURS: begin
          if (r_rem >= c_sec_hr) begin
            r_rem <= r_rem - c_sec_hr;
            r_hrs <= r_hrs + 5'd1;
          end else begin
            r_state <= MINS;
          end
        end
        MINS: begin
          if (r_rem >= c_sec_min) begin
            r_rem  <= r_rem - c_sec_min;
            r_mins <= r_mins + 6'd1;
          end else begin
            // Remainder is now < 60, so the low six bits are the seconds field.
            r_state   <= DONE;
            out_err   <= 1'b0;
            out_hours <= r_hrs;
            out_mins  <= r_mins;
            out_secs  <= r_rem[5:0];
`ifdef CNT_HMS_BCD_EN
            out_bcd   <= w_bcd;
`endif
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
